// File: rtl/pipe_acc_pkg.sv
// Opcode map, ALU control-word table and NOP encoding shared by the
// pipelined accumulator core.
package pipe_acc_pkg;

   localparam logic [4:0] OP_ALU_LAST = 5'd18;
   localparam logic [4:0] OP_STORE    = 5'd19;
   localparam logic [4:0] OP_JMP      = 5'd20;
   localparam logic [4:0] OP_JZ       = 5'd21;
   localparam logic [4:0] OP_JNG      = 5'd22;
   localparam logic [4:0] OP_HALT     = 5'd23;
   localparam logic [4:0] OP_NOP      = 5'd24;

   // Indirect bit and opcode of a NOP; the address field is all zeros.
   localparam logic [5:0] NOP_HI      = {1'b0, OP_NOP};

   localparam logic [5:0] CTL_PASS_X  = 6'b001100;

   // zx,nx,zy,ny,f,no for each opcode; non-ALU opcodes pass acc through.
   function automatic logic [5:0] ctrl_word(input logic [4:0] op);
      logic [5:0] cw;
      case (op)
         5'd0:    cw = 6'b101010;
         5'd1:    cw = 6'b111111;
         5'd2:    cw = 6'b111010;
         5'd3:    cw = 6'b001100;
         5'd4:    cw = 6'b110000;
         5'd5:    cw = 6'b001101;
         5'd6:    cw = 6'b110001;
         5'd7:    cw = 6'b001111;
         5'd8:    cw = 6'b110011;
         5'd9:    cw = 6'b011111;
         5'd10:   cw = 6'b110111;
         5'd11:   cw = 6'b001110;
         5'd12:   cw = 6'b110010;
         5'd13:   cw = 6'b000010;
         5'd14:   cw = 6'b010011;
         5'd15:   cw = 6'b000111;
         5'd16:   cw = 6'b000000;
         5'd17:   cw = 6'b010101;
         5'd18:   cw = 6'b110000;
         5'd19:   cw = CTL_PASS_X;
         5'd20:   cw = CTL_PASS_X;
         5'd21:   cw = CTL_PASS_X;
         5'd22:   cw = CTL_PASS_X;
         5'd23:   cw = CTL_PASS_X;
         default: cw = CTL_PASS_X;
      endcase
      return cw;
   endfunction

endpackage

// File: rtl/pipe_acc_core_calc_w.sv
// DW-bit six-control-bit ALU (zx,nx,zy,ny,f,no), purely combinational.
module calc_w #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   input  logic [5:0]    ctl,
   output logic [DW-1:0] o,
   output logic          ng,
   output logic          zr
);

   logic [DW-1:0] xz_s, xn_s, yz_s, yn_s, f_s;

   // Condition both operands, select add or and, then optionally invert.
   always_comb begin
      xz_s = ctl[5] ? {DW{1'b0}} : x;
      xn_s = ctl[4] ? ~xz_s : xz_s;
      yz_s = ctl[3] ? {DW{1'b0}} : y;
      yn_s = ctl[2] ? ~yz_s : yz_s;
      f_s  = ctl[1] ? (xn_s + yn_s) : (xn_s & yn_s);
      o    = ctl[0] ? ~f_s : f_s;
      ng   = o[DW-1];
      zr   = (o == {DW{1'b0}});
   end

endmodule

// File: rtl/pipe_acc_core.sv
// Three-stage (IF, ID/operand fetch, EX/writeback) accumulator processor with
// operand and store forwarding, indirect-access stall, branch flush and freeze.
module pipe_acc_core
   import pipe_acc_pkg::*;
#(
   parameter int DW       = 16,
   parameter int AW       = 10,
   parameter int RESET_PC = 0
) (
   input  logic            clk1,
   input  logic            rst,
   input  logic            run,
   output logic [AW-1:0]   imem_addr,
   input  logic [AW+5:0]   imem_rdata,
   output logic [AW-1:0]   dmem_raddr,
   input  logic [DW-1:0]   dmem_rdata,
   output logic            dmem_we,
   output logic [AW-1:0]   dmem_waddr,
   output logic [DW-1:0]   dmem_wdata,
   output logic [DW-1:0]   acc,
   output logic            ng,
   output logic            zr,
   output logic            halted
);

   localparam int            IW        = AW + 6;
   localparam logic [AW-1:0] PC_INIT   = AW'(RESET_PC);
   localparam logic [IW-1:0] NOP_INSTR = {NOP_HI, {AW{1'b0}}};
   localparam logic [AW-1:0] PC_ONE    = {{(AW-1){1'b0}}, 1'b1};

   logic [AW-1:0] pc_r, ptr_r, idex_ea_r;
   logic [IW-1:0] ifid_r;
   logic          ind_phase_r, halted_r;
   logic [4:0]    idex_op_r;
   logic [DW-1:0] idex_y_r, acc_r;

   logic          id_stall_s, id_halt_s, id_br_s, id_taken_s, adv_s;
   logic          ex_alu_s, st_hit_s, alu_ng_s, alu_zr_s, cond_ng_s, cond_zr_s;
   logic [4:0]    id_op_s;
   logic [AW-1:0] id_ea_s;
   logic [5:0]    ex_ctl_s;
   logic [DW-1:0] rd_s, alu_o_s;

   // The second indirect cycle reads through the latched pointer.
   assign id_op_s    = ifid_r[IW-2:AW];
   assign id_ea_s    = ind_phase_r ? ptr_r : ifid_r[AW-1:0];
   assign id_stall_s = ifid_r[IW-1] & ~ind_phase_r;
   assign id_halt_s  = (id_op_s == OP_HALT) & ~id_stall_s;
   assign adv_s      = run & ~halted_r;

   assign ex_alu_s   = (idex_op_r <= OP_ALU_LAST);
   assign ex_ctl_s   = ctrl_word(idex_op_r);

   assign imem_addr  = pc_r;
   assign dmem_raddr = id_ea_s;
   assign dmem_we    = adv_s & (idex_op_r == OP_STORE);
   assign dmem_waddr = idex_ea_r;
   assign dmem_wdata = acc_r;
   assign acc        = acc_r;
   assign ng         = acc_r[DW-1];
   assign zr         = (acc_r == {DW{1'b0}});
   assign halted     = halted_r;

   assign st_hit_s   = dmem_we & (dmem_waddr == id_ea_s);
   assign rd_s       = st_hit_s ? dmem_wdata : dmem_rdata;

   calc_w #(.DW(DW)) u_calc (
      .x   (acc_r),
      .y   (idex_y_r),
      .ctl (ex_ctl_s),
      .o   (alu_o_s),
      .ng  (alu_ng_s),
      .zr  (alu_zr_s)
   );

   // Branch decision in ID; flags come from the EX result when EX writes acc.
   always_comb begin
      cond_ng_s = ex_alu_s ? alu_ng_s : acc_r[DW-1];
      cond_zr_s = ex_alu_s ? alu_zr_s : (acc_r == {DW{1'b0}});
      case (id_op_s)
         OP_JMP:  id_br_s = 1'b1;
         OP_JZ:   id_br_s = cond_zr_s;
         OP_JNG:  id_br_s = cond_ng_s;
         default: id_br_s = 1'b0;
      endcase
      id_taken_s = id_br_s & ~id_stall_s;
   end

   // Pipeline state; nothing moves while frozen or after HALT.
   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         pc_r        <= PC_INIT;
         ifid_r      <= NOP_INSTR;
         ind_phase_r <= 1'b0;
         ptr_r       <= {AW{1'b0}};
         idex_op_r   <= OP_NOP;
         idex_ea_r   <= {AW{1'b0}};
         idex_y_r    <= {DW{1'b0}};
         acc_r       <= {DW{1'b0}};
         halted_r    <= 1'b0;
      end else if (adv_s) begin
         if (id_halt_s) begin
            halted_r    <= 1'b1;
            ifid_r      <= NOP_INSTR;
            ind_phase_r <= 1'b0;
            idex_op_r   <= OP_NOP;
            idex_ea_r   <= {AW{1'b0}};
            idex_y_r    <= {DW{1'b0}};
         end else if (id_stall_s) begin
            ind_phase_r <= 1'b1;
            ptr_r       <= rd_s[AW-1:0];
            idex_op_r   <= OP_NOP;
            idex_ea_r   <= {AW{1'b0}};
            idex_y_r    <= {DW{1'b0}};
         end else begin
            ind_phase_r <= 1'b0;
            idex_op_r   <= id_op_s;
            idex_ea_r   <= id_ea_s;
            idex_y_r    <= rd_s;
            if (id_taken_s) begin
               pc_r   <= id_ea_s;
               ifid_r <= NOP_INSTR;
            end else begin
               pc_r   <= pc_r + PC_ONE;
               ifid_r <= imem_rdata;
            end
         end
         if (ex_alu_s) begin
            acc_r <= alu_o_s;
         end else begin
            acc_r <= acc_r;
         end
      end else begin
         halted_r <= halted_r;
      end
   end

endmodule

// File: tb/tb_pipe_acc_core.sv
// Directed timing checks plus random programs compared with an
// instruction-level reference model of the accumulator machine.
module tb_pipe_acc_core;

   localparam int DW = 16;
   localparam int AW = 10;
   localparam logic [15:0] HALT_I = 16'h5C00;

   logic            clk1 = 1'b0;
   logic            rst;
   logic            run;
   logic [AW-1:0]   imem_addr, dmem_raddr, dmem_waddr;
   logic [AW+5:0]   imem_rdata;
   logic [DW-1:0]   dmem_rdata, dmem_wdata, acc;
   logic            dmem_we, ng, zr, halted;

   logic [15:0] imem [0:1023];
   logic [15:0] dmem [0:1023];
   logic [15:0] mdm  [0:1023];
   logic [25:0] dut_st [$];
   logic [25:0] mod_st [$];
   logic [15:0] m_acc;
   int n_assert = 0;
   int n_fail   = 0;

   pipe_acc_core #(.DW(DW), .AW(AW), .RESET_PC(0)) dut (
      .clk1(clk1), .rst(rst), .run(run),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
      .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
      .acc(acc), .ng(ng), .zr(zr), .halted(halted)
   );

   always #5 clk1 = ~clk1;

   assign imem_rdata = imem[imem_addr];
   assign dmem_rdata = dmem[dmem_raddr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic i, input int op, input int a);
      return {i, op[4:0], a[9:0]};
   endfunction

   // One clock: capture the store strobe mid-cycle, commit it just after the edge.
   task automatic tick();
      logic we;
      logic [9:0] wa;
      logic [15:0] wd;
      #4;
      we = dmem_we;
      wa = dmem_waddr;
      wd = dmem_wdata;
      @(posedge clk1);
      #1;
      if (we) begin
         dmem[wa] = wd;
         dut_st.push_back({wa, wd});
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      run = 1'b1;
      @(posedge clk1);
      #1;
      dut_st.delete();
      rst = 1'b1;
   endtask

   task automatic clear_mem();
      for (int k = 0; k < 1024; k++) begin
         imem[k] = HALT_I;
         dmem[k] = 16'h0000;
      end
   endtask

   function automatic logic [15:0] ref_alu(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
      case (op)
         5'd0:  return 16'h0000;
         5'd1:  return 16'h0001;
         5'd2:  return 16'hFFFF;
         5'd3:  return x;
         5'd4:  return y;
         5'd5:  return ~x;
         5'd6:  return ~y;
         5'd7:  return 16'h0000 - x;
         5'd8:  return 16'h0000 - y;
         5'd9:  return x + 16'h0001;
         5'd10: return y + 16'h0001;
         5'd11: return x - 16'h0001;
         5'd12: return y - 16'h0001;
         5'd13: return x + y;
         5'd14: return x - y;
         5'd15: return y - x;
         5'd16: return x & y;
         5'd17: return x | y;
         default: return y;
      endcase
   endfunction

   // Sequential instruction-level execution of the program in imem/dmem.
   task automatic run_model(output bit ok);
      logic [9:0]  pc, pcn, ea, a;
      logic [15:0] ins, y, ac;
      logic [4:0]  op;
      for (int k = 0; k < 1024; k++) mdm[k] = dmem[k];
      mod_st.delete();
      pc = 10'd0;
      ac = 16'h0000;
      ok = 1'b0;
      for (int s = 0; s < 400; s++) begin
         ins = imem[pc];
         op  = ins[14:10];
         a   = ins[9:0];
         ea  = ins[15] ? mdm[a][9:0] : a;
         y   = mdm[ea];
         pcn = pc + 10'd1;
         if (op <= 5'd18) ac = ref_alu(op, ac, y);
         else if (op == 5'd19) begin
            mdm[ea] = ac;
            mod_st.push_back({ea, ac});
         end
         else if (op == 5'd20) pcn = ea;
         else if (op == 5'd21 && ac == 16'h0000) pcn = ea;
         else if (op == 5'd22 && ac[15]) pcn = ea;
         else if (op == 5'd23) begin
            ok = 1'b1;
            break;
         end
         pc = pcn;
      end
      m_acc = ac;
   endtask

   task automatic gen_prog();
      int kind, op, a;
      logic i;
      for (int k = 0; k < 1024; k++) begin
         imem[k] = HALT_I;
         dmem[k] = 16'($urandom);
      end
      for (int p = 0; p < 24; p++) begin
         kind = $urandom_range(0, 9);
         i = 1'b0;
         if (kind <= 5) begin
            op = $urandom_range(0, 18);
            i  = ($urandom_range(0, 3) == 0);
            a  = 100 + $urandom_range(0, 15);
         end else if (kind <= 7) begin
            op = 19;
            i  = ($urandom_range(0, 4) == 0);
            a  = 100 + $urandom_range(0, 15);
         end else if (kind == 8) begin
            op = 20 + $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0) begin
               i = 1'b1;
               a = 116 + $urandom_range(0, 3);
               dmem[a] = {6'($urandom), 10'(p + 1 + $urandom_range(0, 4))};
            end else begin
               a = p + 1 + $urandom_range(0, 4);
            end
         end else begin
            op = 24 + $urandom_range(0, 7);
            i  = ($urandom_range(0, 1) == 1);
            a  = $urandom_range(0, 1023);
         end
         imem[p] = mk(i, op, a);
      end
   endtask

   initial begin
      int exp5 [6];
      bit ok;
      int diffs;
      rst = 1'b0;
      run = 1'b1;
      exp5 = '{0, 0, 7, 7, 7, 16'h1234};

      // Test 1: LOAD/ADD/STORE/HALT, latency and reset state.
      clear_mem();
      dmem[5] = 16'h0007;
      imem[0] = mk(1'b0, 18, 5);
      imem[1] = mk(1'b0, 13, 5);
      imem[2] = mk(1'b0, 19, 6);
      @(posedge clk1);
      #1;
      check("rst_acc", acc, 16'h0000);
      check("rst_halted", halted, 1'b0);
      check("rst_we", dmem_we, 1'b0);
      check("rst_waddr", dmem_waddr, 10'd0);
      check("rst_wdata", dmem_wdata, 16'h0000);
      check("rst_pc", imem_addr, 10'd0);
      do_reset();
      ticks(2);
      check("t1_acc_e2", acc, 16'h0000);
      tick();
      check("t1_acc_e3", acc, 16'h0007);
      tick();
      check("t1_acc_e4", acc, 16'h000E);
      tick();
      check("t1_halt_e5", halted, 1'b1);
      tick();
      check("t1_dmem6", dmem[6], 16'h000E);
      check("t1_acc", acc, 16'h000E);
      ticks(3);
      check("t1_nstores", dut_st.size(), 1);
      check("t1_halt_sticky", halted, 1'b1);

      // Test 6: freeze with a STORE in EX.
      clear_mem();
      dmem[5] = 16'h0007;
      imem[0] = mk(1'b0, 18, 5);
      imem[1] = mk(1'b0, 13, 5);
      imem[2] = mk(1'b0, 19, 6);
      do_reset();
      ticks(4);
      check("t6_we_before", dmem_we, 1'b1);
      run = 1'b0;
      #1;
      check("t6_we_frozen0", dmem_we, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t6_we_frozen", dmem_we, 1'b0);
         check("t6_acc_frozen", acc, 16'h000E);
         check("t6_pc_frozen", imem_addr, 10'd4);
      end
      check("t6_no_store", dut_st.size(), 0);
      run = 1'b1;
      #1;
      check("t6_we_resume", dmem_we, 1'b1);
      ticks(3);
      check("t6_nstores", dut_st.size(), 1);
      check("t6_dmem6", dmem[6], 16'h000E);
      check("t6_halted", halted, 1'b1);

      // Test 2: indirect load stalls fetch one cycle.
      clear_mem();
      dmem[10] = 16'd20;
      dmem[20] = 16'h1234;
      imem[0] = mk(1'b1, 18, 10);
      do_reset();
      tick();
      check("t2_pc_e1", imem_addr, 10'd1);
      tick();
      check("t2_pc_e2", imem_addr, 10'd1);
      tick();
      check("t2_pc_e3", imem_addr, 10'd2);
      tick();
      check("t2_acc", acc, 16'h1234);

      // Test 3a: taken JZ flushes the fall-through instruction.
      clear_mem();
      dmem[5] = 16'h0007;
      imem[0] = mk(1'b0, 24, 0);
      imem[1] = mk(1'b0, 21, 8);
      imem[2] = mk(1'b0, 14, 5);
      imem[8] = mk(1'b0, 18, 5);
      do_reset();
      ticks(3);
      check("t3a_pc", imem_addr, 10'd8);
      ticks(2);
      check("t3a_acc_e5", acc, 16'h0000);
      tick();
      check("t3a_acc_e6", acc, 16'h0007);

      // Test 3b: JZ sees the forwarded EX result and falls through.
      clear_mem();
      dmem[4] = 16'h0003;
      dmem[5] = 16'h0007;
      imem[0] = mk(1'b0, 18, 4);
      imem[1] = mk(1'b0, 21, 8);
      imem[2] = mk(1'b0, 14, 5);
      imem[8] = mk(1'b0, 18, 5);
      do_reset();
      ticks(3);
      check("t3b_pc", imem_addr, 10'd3);
      ticks(2);
      check("t3b_acc", acc, 16'hFFFC);
      check("t3b_halted", halted, 1'b1);

      // Test 4: store-to-load forwarding.
      clear_mem();
      dmem[5]  = 16'h00AA;
      dmem[30] = 16'h5555;
      imem[0] = mk(1'b0, 18, 5);
      imem[1] = mk(1'b0, 19, 30);
      imem[2] = mk(1'b0, 18, 30);
      do_reset();
      ticks(5);
      check("t4_acc", acc, 16'h00AA);
      check("t4_dmem30", dmem[30], 16'h00AA);

      // Test 5: reset during indirect stall with a store in EX.
      clear_mem();
      dmem[5]  = 16'h0007;
      dmem[6]  = 16'hBEEF;
      dmem[10] = 16'd20;
      dmem[20] = 16'h1234;
      imem[0] = mk(1'b0, 18, 5);
      imem[1] = mk(1'b0, 19, 6);
      imem[2] = mk(1'b1, 18, 10);
      do_reset();
      ticks(3);
      check("t5_acc_pre", acc, 16'h0007);
      check("t5_we_pre", dmem_we, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("t5_acc_rst", acc, 16'h0000);
      check("t5_halted_rst", halted, 1'b0);
      check("t5_we_rst", dmem_we, 1'b0);
      @(posedge clk1);
      #1;
      check("t5_no_partial", dmem[6], 16'hBEEF);
      dut_st.delete();
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("t5_trace_e%0d", k + 1), acc, exp5[k]);
      end
      check("t5_halted", halted, 1'b1);
      check("t5_dmem6", dmem[6], 16'h0007);
      check("t5_nstores", dut_st.size(), 1);

      // Random programs against the instruction-level model.
      for (int t = 0; t < 8; t++) begin
         ok = 1'b0;
         for (int g = 0; g < 50 && !ok; g++) begin
            gen_prog();
            run_model(ok);
         end
         check($sformatf("r%0d_gen", t), ok, 1'b1);
         do_reset();
         for (int c = 0; c < 3000 && !halted; c++) begin
            run = (t < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick();
         end
         run = 1'b1;
         check($sformatf("r%0d_halted", t), halted, 1'b1);
         check($sformatf("r%0d_acc", t), acc, m_acc);
         check($sformatf("r%0d_nstores", t), dut_st.size(), mod_st.size());
         for (int k = 0; k < dut_st.size() && k < mod_st.size(); k++)
            check($sformatf("r%0d_store%0d", t, k), dut_st[k], mod_st[k]);
         diffs = 0;
         for (int k = 0; k < 1024; k++)
            if (dmem[k] !== mdm[k]) diffs++;
         check($sformatf("r%0d_mem_diffs", t), diffs, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
